wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and a

---
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order WB stage and a
// long-latency unit (LU). LU results wait in a small FIFO. The WB stage normally
// wins the port. A wait counter bounds how long a non-empty FIFO can be passed
// over. When the bound is reached, the FIFO head is written and the pipeline is
// stalled for one cycle.

module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // WB stage request
  input  logic              pipe_valid_i,
  input  logic              pipe_we_i,
  input  logic [REG_W-1:0]  pipe_dest_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              pipe_stall_o,
  // LU result stream
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [REG_W-1:0]  lu_dest_i,
  input  logic [DATA_W-1:0] lu_wdata_i,
  output logic              lu_pending_o,
  // Register-file write port
  output logic              rf_we_o,
  output logic [REG_W-1:0]  rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_BUF  = 2'd2
  } grant_e;

  // FIFO storage and bookkeeping
  logic [REG_W-1:0]  r_buf_dest [BUF_DEPTH];
  logic [DATA_W-1:0] r_buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait_cnt;

  // Combinational decode
  logic              w_pipe_req;
  logic              w_buf_req;
  logic              w_not_full;
  logic              w_force;
  logic              w_accept;
  logic              w_enq;
  logic              w_deq;
  grant_e            w_grant;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;

  assign w_pipe_req = pipe_valid_i & pipe_we_i & (pipe_dest_i != '0);
  assign w_buf_req  = (r_count != '0);
  assign w_not_full = (r_count != FULL_CNT);
  assign w_force    = w_buf_req & (r_wait_cnt == WAIT_LIM);

  // Ready depends only on the registered count. It is also held low while reset
  // is asserted.
  assign lu_ready_o   = rst_ni & w_not_full;
  assign lu_pending_o = w_buf_req;

  // A result for x0 completes the handshake but is dropped instead of queued.
  assign w_accept = lu_valid_i & lu_ready_o;
  assign w_enq    = w_accept & (lu_dest_i != '0);
  assign w_deq    = (w_grant == GRANT_BUF);

  // Decide the port owner: a forced or uncontested FIFO first, otherwise WB.
  always_comb begin
    w_grant = GRANT_NONE;
    if (w_force || (w_buf_req && !w_pipe_req)) begin
      w_grant = GRANT_BUF;
    end else if (w_pipe_req) begin
      w_grant = GRANT_PIPE;
    end
  end

  // Drive the register-file port from the granted source. The port is zero when idle.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    case (w_grant)
      GRANT_BUF: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_buf_dest[r_rd_ptr];
        rf_wdata_o = r_buf_data[r_rd_ptr];
      end
      GRANT_PIPE: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = pipe_dest_i;
        rf_wdata_o = pipe_wdata_i;
      end
      default: ;
    endcase
  end

  // The WB write is held only when it loses the port to a forced FIFO write.
  assign pipe_stall_o = w_force & w_pipe_req;

  // Compute the next occupancy from the enqueue and dequeue strobes.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Count consecutive cycles in which a queued result loses to WB. Reset the
  // count when the FIFO is granted or is empty.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!w_buf_req || (w_grant == GRANT_BUF)) begin
      w_wait_nxt = '0;
    end else if (w_pipe_req && (r_wait_cnt != WAIT_LIM)) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  // Write the FIFO payload. Slot contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload array has no reset; occupancy is tracked by r_count,
    // so a stale slot is never presented.
    if (w_enq) begin
      r_buf_dest[r_wr_ptr] <= lu_dest_i;
      r_buf_data[r_wr_ptr] <= lu_wdata_i;
    end
  end

  // Update the pointers, count and wait counter. Reset discards everything queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values.
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter with the default parameters (BUF_DEPTH=2, MAX_WAIT=4).
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
// well before the next rising edge.

module tb_wb_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pipe_valid_i, pipe_we_i;
  logic [4:0]  pipe_dest_i;
  logic [31:0] pipe_wdata_i;
  logic        pipe_stall_o;
  logic        lu_valid_i, lu_ready_o;
  logic [4:0]  lu_dest_i;
  logic [31:0] lu_wdata_i;
  logic        lu_pending_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(.DATA_W(32), .REG_W(5), .BUF_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pipe_valid_i (pipe_valid_i),
    .pipe_we_i    (pipe_we_i),
    .pipe_dest_i  (pipe_dest_i),
    .pipe_wdata_i (pipe_wdata_i),
    .pipe_stall_o (pipe_stall_o),
    .lu_valid_i   (lu_valid_i),
    .lu_ready_o   (lu_ready_o),
    .lu_dest_i    (lu_dest_i),
    .lu_wdata_i   (lu_wdata_i),
    .lu_pending_o (lu_pending_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  // Per-cycle vector: inputs and the outputs expected 1 ns after they are applied.
  typedef struct {
    string       name;
    logic        pv, pwe;
    logic [4:0]  pdest;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  ldest;
    logic [31:0] ldata;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall, e_ready, e_pend;
  } vec_t;

  // Record of one LU write seen on the register-file port.
  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
  } lu_wr_t;

  vec_t   vecs[$];
  lu_wr_t lu_wr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name,
                              input logic pv, input logic pwe, input logic [4:0] pdest,
                              input logic [31:0] pdata, input logic lv, input logic [4:0] ldest,
                              input logic [31:0] ldata, input logic e_we, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input logic e_stall,
                              input logic e_ready, input logic e_pend);
    vec_t v;
    v.name = name; v.pv = pv; v.pwe = pwe; v.pdest = pdest; v.pdata = pdata;
    v.lv = lv; v.ldest = ldest; v.ldata = ldata;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic drive(input logic pv, input logic pwe, input logic [4:0] pdest,
                       input logic [31:0] pdata, input logic lv, input logic [4:0] ldest,
                       input logic [31:0] ldata);
    pipe_valid_i = pv; pipe_we_i = pwe; pipe_dest_i = pdest; pipe_wdata_i = pdata;
    lu_valid_i = lv; lu_dest_i = ldest; lu_wdata_i = ldata;
  endtask

  // Watchdog so a broken design cannot hang the run.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb_idx, lu_idx;
    logic lu_took, wb_took;

    rst_ni = 1'b0;
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    // Outputs while reset is held.
    check("rst_ready", lu_ready_o, 0);
    check("rst_pend", lu_pending_o, 0);
    check("rst_stall", pipe_stall_o, 0);
    check("rst_rf_we", rf_we_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Consecutive cycles starting from an empty FIFO.
    //                name         pv pwe pdest  pdata        lv ldest  ldata        we addr   data         st rdy pend
    vecs.push_back(mk("idle0",      0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("wb_x5",      1, 1, 5'd5,  32'hA5,       0, 5'd0,  32'h0,        1, 5'd5,  32'hA5,       0, 1, 0));
    vecs.push_back(mk("lu_x7_in",   0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h11,       0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("lu_x7_wr",   0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'h11,       0, 1, 1));
    vecs.push_back(mk("lu_x7_done", 0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("x0_both",    1, 1, 5'd0,  32'h55,       1, 5'd0,  32'h66,       0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("x0_after",   0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("nowe_lu_x9", 1, 0, 5'd3,  32'h33,       1, 5'd9,  32'h99,       0, 5'd0,  32'h0,        0, 1, 0));
    vecs.push_back(mk("starve_w0",  1, 1, 5'd1,  32'h101,      0, 5'd0,  32'h0,        1, 5'd1,  32'h101,      0, 1, 1));
    vecs.push_back(mk("starve_w1",  1, 1, 5'd2,  32'h102,      0, 5'd0,  32'h0,        1, 5'd2,  32'h102,      0, 1, 1));
    vecs.push_back(mk("starve_w2",  1, 1, 5'd3,  32'h103,      0, 5'd0,  32'h0,        1, 5'd3,  32'h103,      0, 1, 1));
    vecs.push_back(mk("starve_w3",  1, 1, 5'd4,  32'h104,      0, 5'd0,  32'h0,        1, 5'd4,  32'h104,      0, 1, 1));
    vecs.push_back(mk("force_buf",  1, 1, 5'd5,  32'h105,      0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       1, 1, 1));
    vecs.push_back(mk("held_wb",    1, 1, 5'd5,  32'h105,      0, 5'd0,  32'h0,        1, 5'd5,  32'h105,      0, 1, 0));
    vecs.push_back(mk("lu_xa_in",   1, 1, 5'd6,  32'h106,      1, 5'd10, 32'hAA,       1, 5'd6,  32'h106,      0, 1, 0));
    vecs.push_back(mk("nowe_buf",   1, 0, 5'd6,  32'h0,        0, 5'd0,  32'h0,        1, 5'd10, 32'hAA,       0, 1, 1));
    vecs.push_back(mk("idle_end",   0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0));

    @(negedge clk_i);
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pwe, vecs[i].pdest, vecs[i].pdata,
            vecs[i].lv, vecs[i].ldest, vecs[i].ldata);
      #1;
      check({vecs[i].name, "_we"},    rf_we_o,      vecs[i].e_we);
      check({vecs[i].name, "_addr"},  rf_waddr_o,   vecs[i].e_addr);
      check({vecs[i].name, "_data"},  rf_wdata_o,   vecs[i].e_data);
      check({vecs[i].name, "_stall"}, pipe_stall_o, vecs[i].e_stall);
      check({vecs[i].name, "_ready"}, lu_ready_o,   vecs[i].e_ready);
      check({vecs[i].name, "_pend"},  lu_pending_o, vecs[i].e_pend);
      @(negedge clk_i);
    end

    // Three LU results back-to-back under a continuous WB stream.
    // Expected: the FIFO fills after two results, so ready is low in cycles 2..5.
    // Forced FIFO writes occur in cycles 5, 10 and 15. The third result is
    // accepted in cycle 6.
    wb_idx = 0;
    lu_idx = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 5'(1 + (wb_idx % 3)), 32'h200 + 32'(wb_idx),
            lu_idx < 3, 5'(20 + lu_idx), 32'h300 + 32'(lu_idx));
      #1;
      if (c == 2) check("t4_ready_full", lu_ready_o, 0);
      if (c == 5) check("t4_ready_full_deq", lu_ready_o, 0);
      if (c == 6) check("t4_ready_after_deq", lu_ready_o, 1);
      if (rf_we_o && rf_waddr_o >= 5'd20) begin
        lu_wr.push_back('{cyc: c, addr: rf_waddr_o, data: rf_wdata_o, stall: pipe_stall_o});
      end else begin
        check("t4_wb_we", rf_we_o, 1);
        check("t4_wb_data", rf_wdata_o, 32'h200 + 32'(wb_idx));
      end
      lu_took = lu_valid_i & lu_ready_o;
      wb_took = ~pipe_stall_o;
      @(negedge clk_i);
      if (lu_took) lu_idx++;
      if (wb_took) wb_idx++;
    end
    check("t4_lu_accepted", lu_idx, 3);
    check("t4_wb_commits", wb_idx, 17);
    check("t4_lu_writes", lu_wr.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < lu_wr.size()) begin
        check("t4_lu_cycle", lu_wr[k].cyc, 5 + 5 * k);
        check("t4_lu_addr",  lu_wr[k].addr, 20 + k);
        check("t4_lu_data",  lu_wr[k].data, 32'h300 + 32'(k));
        check("t4_lu_stall", lu_wr[k].stall, 1);
      end
    end

    // Reset asserted with two queued entries.
    drive(1, 1, 5'd1, 32'h401, 1, 5'd11, 32'h411);
    @(negedge clk_i);
    drive(1, 1, 5'd2, 32'h402, 1, 5'd12, 32'h412);
    @(negedge clk_i);
    drive(1, 1, 5'd3, 32'h403, 0, 5'd0, 32'h0);
    #1;
    check("t6_pend_before", lu_pending_o, 1);
    check("t6_full_before", lu_ready_o, 0);
    rst_ni = 1'b0;
    #1;
    check("t6_pend_in_rst", lu_pending_o, 0);
    check("t6_ready_in_rst", lu_ready_o, 0);
    check("t6_stall_in_rst", pipe_stall_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t6_no_stale_we", rf_we_o, 0);
      check("t6_pend_after", lu_pending_o, 0);
      check("t6_ready_after", lu_ready_o, 1);
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
